// File: rtl/and_gate.sv
// and_gate: bitwise AND of two operands with a registered shadow of the result,
// per-bit rising-edge flags and an optional saturating all-ones cycle counter.
// Build option: define AND_GATE_STATS_EN to include the statistics counter.
// Without it, hi_count drives constant 0 and clr is ignored. The port list is
// the same in both builds.
module and_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             all_ones,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] y_rise,
  input  logic             clr,
  output logic [CNT_W-1:0] hi_count
);

  // Pure gate path: no state between the operands and y.
  assign y        = a & b;
  assign all_ones = &y;

  // Shadow register and edge flags; the edge compares the new y with the old shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      y_rise <= '0;
    end else begin
      y_rise <= y & ~y_q;
      y_q    <= y;
    end
  end

`ifdef AND_GATE_STATS_EN
  logic [CNT_W-1:0] hi_count_q;

  // Saturating count of all-ones cycles; clr beats counting and reset beats clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hi_count_q <= '0;
    end else if (all_ones && (hi_count_q != {CNT_W{1'b1}})) begin
      hi_count_q <= hi_count_q + 1'b1;
    end
  end

  assign hi_count = hi_count_q;
`else
  // clr is part of the port list but has no function in this build.
  logic unused_clr;
  assign unused_clr = clr;
  assign hi_count   = '0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: directed scenarios followed by random
// stimulus, compared against a cycle-level behavioural model.
module tb_and_gate;

  localparam int unsigned W1 = 1;
  localparam int unsigned C1 = 16;
  localparam int unsigned W4 = 4;
  localparam int unsigned C4 = 2;

  logic          clk;
  logic          rst;
  logic          clr;
  logic [W1-1:0] a1, b1, y1, yq1, yr1;
  logic          ao1;
  logic [C1-1:0] hc1;
  logic [W4-1:0] a4, b4, y4, yq4, yr4;
  logic          ao4;
  logic [C4-1:0] hc4;

  int checks;
  int failures;

  // Behavioural model state: previous y value, edge flags and counter as integers.
  int m1_yq, m1_rise, m1_cnt;
  int m4_yq, m4_rise, m4_cnt;

  and_gate #(.WIDTH(W1), .CNT_W(C1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .all_ones(ao1),
    .y_q(yq1), .y_rise(yr1), .clr(clr), .hi_count(hc1)
  );

  and_gate #(.WIDTH(W4), .CNT_W(C4)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .all_ones(ao4),
    .y_q(yq4), .y_rise(yr4), .clr(clr), .hi_count(hc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_cnt(input int cnt, input int rst_v, input int clr_v,
                                   input int yv, input int width, input int cw);
    int full;
    int maxv;
    full = (1 << width) - 1;
    maxv = (1 << cw) - 1;
`ifdef AND_GATE_STATS_EN
    if (rst_v != 0 || clr_v != 0) return 0;
    if (yv == full && cnt < maxv) return cnt + 1;
    return cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".y1"},   64'(y1),   64'(a1 & b1));
    chk({tag, ".ao1"},  64'(ao1),  64'((a1 & b1) == 1));
    chk({tag, ".yq1"},  64'(yq1),  64'(m1_yq));
    chk({tag, ".yr1"},  64'(yr1),  64'(m1_rise));
    chk({tag, ".hc1"},  64'(hc1),  64'(m1_cnt));
    chk({tag, ".y4"},   64'(y4),   64'(a4 & b4));
    chk({tag, ".ao4"},  64'(ao4),  64'((a4 & b4) == 15));
    chk({tag, ".yq4"},  64'(yq4),  64'(m4_yq));
    chk({tag, ".yr4"},  64'(yr4),  64'(m4_rise));
    chk({tag, ".hc4"},  64'(hc4),  64'(m4_cnt));
  endtask

  // Advance one clock edge, step the model with the pre-edge inputs, then check.
  task automatic tick(input string tag);
    int r, c, v1, v4;
    r  = int'(rst);
    c  = int'(clr);
    v1 = int'(a1) & int'(b1);
    v4 = int'(a4) & int'(b4);
    @(posedge clk);
    m1_cnt = model_cnt(m1_cnt, r, c, v1, W1, C1);
    m4_cnt = model_cnt(m4_cnt, r, c, v4, W4, C4);
    if (r != 0) begin
      m1_yq = 0; m1_rise = 0; m4_yq = 0; m4_rise = 0;
    end else begin
      m1_rise = v1 & ~m1_yq;  m1_yq = v1;
      m4_rise = v4 & ~m4_yq;  m4_yq = v4;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [1:0] ab;
    checks = 0; failures = 0;
    m1_yq = 0; m1_rise = 0; m1_cnt = 0;
    m4_yq = 0; m4_rise = 0; m4_cnt = 0;
    rst = 1'b1; clr = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0;

    // Truth table, combinational only.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      #5;
      chk("tt.y", 64'(y1), 64'(i == 3));
    end

    // Reset held for two edges.
    a1 = '0; b1 = '0;
    tick("rst0");
    tick("rst1");
    chk("rst.yq", 64'(yq1), 64'd0);

    // Release with all-ones operands; CNT_W=2 saturates at 3.
    a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    rst = 1'b0;
    tick("rel0");
    chk("rel0.yr1", 64'(yr1), 64'd1);
    tick("rel1");
    chk("rel1.yr1", 64'(yr1), 64'd0);
    tick("sat2");
    tick("sat3");
    tick("sat4");
`ifdef AND_GATE_STATS_EN
    chk("sat.hc4", 64'(hc4), 64'd3);
`else
    chk("nostats.hc4", 64'(hc4), 64'd0);
`endif

    // WIDTH=4 combinational patterns.
    a4 = 4'b1100; b4 = 4'b1010; #1;
    chk("w4.y", 64'(y4), 64'b1000);
    chk("w4.ao", 64'(ao4), 64'd0);
    a4 = 4'hF; b4 = 4'hF; #1;
    chk("w4f.y", 64'(y4), 64'hF);
    chk("w4f.ao", 64'(ao4), 64'd1);

    // clr pulse while all-ones, then counting resumes.
    clr = 1'b1;
    tick("clr");
    clr = 1'b0;
    tick("clr_resume");

    // rst and clr together.
    rst = 1'b1; clr = 1'b1;
    tick("rstclr");
    rst = 1'b0; clr = 1'b0;

    // Random stimulus against the model.
    for (int i = 0; i < 300; i++) begin
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      a4  = 4'($urandom);
      b4  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 3) == 0) a4 = 4'hF;
      rst = ($urandom_range(0, 40) == 0);
      clr = ($urandom_range(0, 25) == 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
